// File: rtl/mips_mc_controller_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, funct codes,
// ALU operation classes and the FSM state encoding.
package mips_mc_controller_pkg;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUOP_ADD is the all-zero code so states that do not use the ALU default to add.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    function automatic logic is_supported_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder: maps the controller's aluop class and the
// instruction funct field onto the ALU control code.
module mips_alu_decoder
    import mips_mc_controller_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [5:0]  funct,
    output logic [2:0]  alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                // Unrecognised funct codes fall back to add; no write is suppressed.
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    default:   alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: state register, next-state logic and Moore
// output decode for the shared-memory datapath.
module mips_mc_controller
    import mips_mc_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pc_en,
    output logic        iord,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_src,
    output logic [2:0]  alu_control,
    output logic        illegal_op
);

    state_t state, next_state;
    aluop_t aluop;
    logic   pc_write, branch;
    logic   mem_write_s, ir_write_s, reg_write_s;

    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values; blocking here would race other clocked logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = RTYPEEX;
                    OP_BEQ:       next_state = BEQEX;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JEX;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR:  next_state = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   next_state = MEMWB;
            RTYPEEX: next_state = RTYPEWB;
            ADDIEX:  next_state = ADDIWB;
            default: next_state = FETCH;
        endcase
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        iord        = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write_s = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        pc_write    = 1'b0;
        branch      = 1'b0;
        aluop       = ALUOP_ADD;
        case (state)
            FETCH:   begin ir_write_s = 1'b1; alu_src_b = 2'b01; pc_write = 1'b1; end
            DECODE:  alu_src_b = 2'b11;
            MEMADR:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
            MEMRD:   iord = 1'b1;
            MEMWB:   begin mem_to_reg = 1'b1; reg_write_s = 1'b1; end
            MEMWR:   begin iord = 1'b1; mem_write_s = 1'b1; end
            RTYPEEX: begin alu_src_a = 1'b1; aluop = ALUOP_FUNCT; end
            RTYPEWB: begin reg_dst = 1'b1; reg_write_s = 1'b1; end
            BEQEX:   begin alu_src_a = 1'b1; aluop = ALUOP_SUB; pc_src = 2'b01; branch = 1'b1; end
            ADDIEX:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
            ADDIWB:  reg_write_s = 1'b1;
            JEX:     begin pc_src = 2'b10; pc_write = 1'b1; end
            default: ;
        endcase
    end

    // Write-type strobes are gated by reset so an aborted instruction cannot
    // commit anything while the state register is held in FETCH.
    assign pc_en      = ~reset & (pc_write | (branch & zero));
    assign ir_write   = ~reset & ir_write_s;
    assign reg_write  = ~reset & reg_write_s;
    assign mem_write  = ~reset & mem_write_s;
    assign illegal_op = ~reset & (state == DECODE) & ~is_supported_op(op);

    mips_alu_decoder u_alu_decoder (
        .aluop       (aluop),
        .funct       (funct),
        .alu_control (alu_control)
    );

endmodule
